// File: rtl/bsg_manycore_reset_sequencer.sv
// bsg_manycore_reset_sequencer
//
// Holds a set of reset domains in reset until tag programming completes,
// then releases the enabled domains one at a time with a fixed stagger and
// starts a free-running global cycle counter once all of them are out of
// reset. A missing tag-done is flagged by a sticky timeout. If tag-done
// drops after the sequence has started, every domain goes back into reset
// and the sequencer waits for tag-done again.
//
// Ports:
//   clk_i          - single clock
//   reset_i        - asynchronous, active-high reset
//   tag_done_i     - level, high once tag programming is complete
//   channel_en_i   - per-channel enable, latched when sequencing starts
//   reset_o        - per-channel active-high reset (registered)
//   all_released_o - every enabled channel is out of reset
//   timeout_o      - sticky, tag-done did not arrive in time
//   global_ctr_o   - cycles since all_released_o rose (wraps)

module bsg_manycore_reset_sequencer #(
    parameter int num_channels_p   = 4,
    parameter int sync_depth_p     = 3,
    parameter int stagger_cycles_p = 16,
    parameter int timeout_cycles_p = 1024,
    parameter int ctr_width_p      = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      tag_done_i,
    input  logic [num_channels_p-1:0] channel_en_i,
    output logic [num_channels_p-1:0] reset_o,
    output logic                      all_released_o,
    output logic                      timeout_o,
    output logic [ctr_width_p-1:0]    global_ctr_o
);

    localparam int wait_w_lp = (timeout_cycles_p > 0) ? $clog2(timeout_cycles_p + 1) : 1;
    localparam int stag_w_lp = (stagger_cycles_p > 1) ? $clog2(stagger_cycles_p) : 1;

    localparam logic [wait_w_lp-1:0] wait_last_lp =
        wait_w_lp'((timeout_cycles_p > 0) ? timeout_cycles_p - 1 : 0);
    localparam logic [stag_w_lp-1:0] stag_last_lp = stag_w_lp'(stagger_cycles_p - 1);

    localparam logic [1:0] wait_tag_s = 2'd0;
    localparam logic [1:0] release_s  = 2'd1;
    localparam logic [1:0] done_s     = 2'd2;
    localparam logic [1:0] timeout_s  = 2'd3;

    logic [1:0]                state_r, state_n;
    logic [sync_depth_p-1:0]   tag_sync_r;
    logic                      tagd;
    logic                      tag_drop;
    logic [wait_w_lp-1:0]      wait_ctr_r, wait_ctr_n;
    logic [stag_w_lp-1:0]      stag_ctr_r, stag_ctr_n;
    logic [num_channels_p-1:0] mask_r, mask_n;
    logic [num_channels_p-1:0] reset_n;
    logic                      all_released_n;
    logic                      timeout_n;
    logic [ctr_width_p-1:0]    global_ctr_n;
    logic [num_channels_p-1:0] pending;
    logic [num_channels_p-1:0] next_bit;

    // Isolates the lowest set bit: the next channel in ascending order.
    function automatic logic [num_channels_p-1:0] lowest_set(input logic [num_channels_p-1:0] v);
        return v & (~v + num_channels_p'(1));
    endfunction

    assign tagd     = tag_sync_r[sync_depth_p-1];
    assign tag_drop = !tagd && (state_r == release_s || state_r == done_s);

    // Tag-done delay chain
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_sync_r <= '0;
        end else begin
            tag_sync_r[0] <= tag_done_i;
            for (int i = 1; i < sync_depth_p; i++) begin
                tag_sync_r[i] <= tag_sync_r[i-1];
            end
        end
    end

    always_comb begin
        state_n        = state_r;
        wait_ctr_n     = wait_ctr_r;
        stag_ctr_n     = stag_ctr_r;
        mask_n         = mask_r;
        reset_n        = reset_o;
        all_released_n = all_released_o;
        timeout_n      = timeout_o;
        global_ctr_n   = global_ctr_o;
        pending        = '0;
        next_bit       = '0;

        case (state_r)
            wait_tag_s: begin
                wait_ctr_n = wait_ctr_r + wait_w_lp'(1);
                if (tagd) begin
                    // The first enabled channel is released on the same edge
                    // the mask is captured, so it is taken from the live input.
                    mask_n     = channel_en_i;
                    next_bit   = lowest_set(channel_en_i);
                    reset_n    = ~next_bit;
                    stag_ctr_n = '0;
                    if (channel_en_i != '0 && (channel_en_i & ~next_bit) == '0) begin
                        state_n        = done_s;
                        all_released_n = 1'b1;
                    end else begin
                        state_n = release_s;
                    end
                end else if (timeout_cycles_p != 0 && wait_ctr_r == wait_last_lp) begin
                    state_n   = timeout_s;
                    timeout_n = 1'b1;
                end
            end
            release_s: begin
                // Enabled channels still held in reset.
                pending  = mask_r & reset_o;
                next_bit = lowest_set(pending);
                if (pending == '0) begin
                    // Empty mask: nothing to release.
                    state_n        = done_s;
                    all_released_n = 1'b1;
                end else if (stag_ctr_r == stag_last_lp) begin
                    reset_n    = reset_o & ~next_bit;
                    stag_ctr_n = '0;
                    if ((pending & ~next_bit) == '0) begin
                        state_n        = done_s;
                        all_released_n = 1'b1;
                    end
                end else begin
                    stag_ctr_n = stag_ctr_r + stag_w_lp'(1);
                end
            end
            done_s: begin
                global_ctr_n = global_ctr_o + ctr_width_p'(1);
            end
            default: begin
                // Timeout is terminal until reset.
            end
        endcase

        // A tag drop overrides anything scheduled for this edge.
        if (tag_drop) begin
            state_n        = wait_tag_s;
            reset_n        = '1;
            all_released_n = 1'b0;
            global_ctr_n   = '0;
            wait_ctr_n     = '0;
            stag_ctr_n     = '0;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r        <= wait_tag_s;
            wait_ctr_r     <= '0;
            stag_ctr_r     <= '0;
            mask_r         <= '0;
            reset_o        <= '1;
            all_released_o <= 1'b0;
            timeout_o      <= 1'b0;
            global_ctr_o   <= '0;
        end else begin
            state_r        <= state_n;
            wait_ctr_r     <= wait_ctr_n;
            stag_ctr_r     <= stag_ctr_n;
            mask_r         <= mask_n;
            reset_o        <= reset_n;
            all_released_o <= all_released_n;
            timeout_o      <= timeout_n;
            global_ctr_o   <= global_ctr_n;
        end
    end

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// Testbench for bsg_manycore_reset_sequencer: directed scenarios followed by
// randomized tag-done / enable / reset traffic, checked every cycle against
// an event-time reference model.

module tb_bsg_manycore_reset_sequencer;

    localparam int N  = 4;
    localparam int SD = 3;
    localparam int ST = 16;
    localparam int TO = 20;
    localparam int CW = 32;

    localparam int M_WAIT = 0;
    localparam int M_SEQ  = 1;
    localparam int M_TO   = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          tag_done_i;
    logic [N-1:0]  channel_en_i;
    logic [N-1:0]  reset_o;
    logic          all_released_o;
    logic          timeout_o;
    logic [CW-1:0] global_ctr_o;

    always #5 clk = ~clk;

    bsg_manycore_reset_sequencer #(
        .num_channels_p  (N),
        .sync_depth_p    (SD),
        .stagger_cycles_p(ST),
        .timeout_cycles_p(TO),
        .ctr_width_p     (CW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .tag_done_i    (tag_done_i),
        .channel_en_i  (channel_en_i),
        .reset_o       (reset_o),
        .all_released_o(all_released_o),
        .timeout_o     (timeout_o),
        .global_ctr_o  (global_ctr_o)
    );

    int vectors     = 0;
    int miscompares = 0;
    int e           = 0;   // index of the most recent clock edge
    bit hist [0:8191];     // tag_done_i as sampled at each edge (0 under reset)
    bit scramble_en = 1'b0;

    // Reference model: sequencing described by event times.
    int           mode  = M_WAIT;
    int           s     = 0;   // edge at which sequencing started
    int           wbase = 0;   // edge after which the wait window restarts
    logic [N-1:0] m     = '0;
    logic [N-1:0] exp_rst;
    logic         exp_all;
    logic         exp_to;
    logic [CW-1:0] exp_ctr;

    task automatic model_outputs();
        int cnt, nrel, done_e, k;
        exp_rst = '1;
        exp_all = 1'b0;
        exp_to  = (mode == M_TO);
        exp_ctr = '0;
        if (mode == M_SEQ) begin
            cnt    = $countones(m);
            done_e = (cnt > 0) ? s + (cnt - 1) * ST : s + 1;
            nrel   = (e - s) / ST + 1;
            if (nrel > cnt) nrel = cnt;
            k = 0;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    if (k < nrel) exp_rst[i] = 1'b0;
                    k++;
                end
            end
            exp_all = (e >= done_e);
            if (exp_all) exp_ctr = CW'(e - done_e);
        end
    endtask

    task automatic model_edge();
        bit td;
        e++;
        hist[e] = reset_i ? 1'b0 : tag_done_i;
        if (reset_i) begin
            mode  = M_WAIT;
            wbase = e;
        end else begin
            td = (e >= SD) ? hist[e-SD] : 1'b0;
            if (mode == M_WAIT) begin
                if (td) begin
                    mode = M_SEQ;
                    s    = e;
                    m    = channel_en_i;
                end else if (e == wbase + TO) begin
                    mode = M_TO;
                end
            end else if (mode == M_SEQ && !td) begin
                mode  = M_WAIT;
                wbase = e;
            end
        end
        model_outputs();
    endtask

    task automatic model_async_reset();
        mode = M_WAIT;
        model_outputs();
    endtask

    task automatic cmp(string tag, logic [31:0] got, logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, got, want);
        end
    endtask

    task automatic check_model();
        cmp("model_reset_o", 32'(reset_o), 32'(exp_rst));
        cmp("model_all_released", 32'(all_released_o), 32'(exp_all));
        cmp("model_timeout", 32'(timeout_o), 32'(exp_to));
        cmp("model_global_ctr", global_ctr_o, exp_ctr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        if (scramble_en) channel_en_i = N'($urandom);
    endtask

    task automatic tick_to(int t0, int rel);
        while (e - t0 < rel) tick();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (4) tick();
    endtask

    int t0, t1, r, rst_hold;

    initial begin
        reset_i      = 1'b1;
        tag_done_i   = 1'b0;
        channel_en_i = 4'b1111;

        // Reset state
        repeat (4) tick();
        cmp("rst_reset_o", 32'(reset_o), 32'hF);
        cmp("rst_all_released", 32'(all_released_o), 32'h0);
        cmp("rst_timeout", 32'(timeout_o), 32'h0);
        cmp("rst_global_ctr", global_ctr_o, 32'h0);

        // Default release, enables ignored once latched
        reset_i = 1'b0; tag_done_i = 1'b1; channel_en_i = 4'b1111;
        tick(); t0 = e;
        tick_to(t0, 2);  cmp("dflt_pre_release", 32'(reset_o), 32'hF);
        tick_to(t0, 3);  cmp("dflt_ch0", 32'(reset_o), 32'hE);
        scramble_en = 1'b1;
        tick_to(t0, 18); cmp("dflt_ch1_early", 32'(reset_o), 32'hE);
        tick_to(t0, 19); cmp("dflt_ch1", 32'(reset_o), 32'hC);
        tick_to(t0, 35); cmp("dflt_ch2", 32'(reset_o), 32'h8);
        tick_to(t0, 50); cmp("dflt_all_early", 32'(all_released_o), 32'h0);
        tick_to(t0, 51); cmp("dflt_ch3", 32'(reset_o), 32'h0);
        cmp("dflt_all", 32'(all_released_o), 32'h1);
        cmp("dflt_ctr0", global_ctr_o, 32'h0);
        tick_to(t0, 56); cmp("dflt_ctr5", global_ctr_o, 32'h5);
        scramble_en = 1'b0;

        // Asynchronous reset in mid-DONE
        #1 reset_i = 1'b1;
        #1;
        cmp("async_reset_o", 32'(reset_o), 32'hF);
        cmp("async_all_released", 32'(all_released_o), 32'h0);
        cmp("async_global_ctr", global_ctr_o, 32'h0);
        model_async_reset();
        repeat (4) tick();

        // Sparse enables
        reset_i = 1'b0; tag_done_i = 1'b1; channel_en_i = 4'b1010;
        tick(); t0 = e;
        tick_to(t0, 3);  cmp("sparse_first", 32'(reset_o), 32'hD);
        tick_to(t0, 18); cmp("sparse_hold", 32'(reset_o), 32'hD);
        cmp("sparse_all_early", 32'(all_released_o), 32'h0);
        tick_to(t0, 19); cmp("sparse_second", 32'(reset_o), 32'h5);
        cmp("sparse_all", 32'(all_released_o), 32'h1);
        tick_to(t0, 25); cmp("sparse_ctr", global_ctr_o, 32'h6);
        do_reset();

        // Tag drop mid-sequence, then restart
        reset_i = 1'b0; tag_done_i = 1'b1; channel_en_i = 4'b1111;
        tick(); t0 = e;
        tick_to(t0, 24); tag_done_i = 1'b0;
        tick_to(t0, 27); cmp("drop_before", 32'(reset_o), 32'hC);
        tick_to(t0, 28); cmp("drop_reassert", 32'(reset_o), 32'hF);
        cmp("drop_all", 32'(all_released_o), 32'h0);
        tick_to(t0, 29); cmp("drop_hold", 32'(reset_o), 32'hF);
        tag_done_i = 1'b1;
        tick(); t1 = e;
        tick_to(t1, 2);  cmp("restart_pre", 32'(reset_o), 32'hF);
        tick_to(t1, 3);  cmp("restart_ch0", 32'(reset_o), 32'hE);
        tick_to(t1, 18); cmp("restart_gap", 32'(reset_o), 32'hE);
        tick_to(t1, 19); cmp("restart_ch1", 32'(reset_o), 32'hC);
        do_reset();

        // Empty mask
        reset_i = 1'b0; tag_done_i = 1'b1; channel_en_i = 4'b0000;
        tick(); t0 = e;
        tick_to(t0, 3);  cmp("zero_all_early", 32'(all_released_o), 32'h0);
        tick_to(t0, 4);  cmp("zero_all", 32'(all_released_o), 32'h1);
        cmp("zero_reset_o", 32'(reset_o), 32'hF);
        tick_to(t0, 10); cmp("zero_ctr", global_ctr_o, 32'h6);
        do_reset();

        // Timeout, then tag_done ignored
        r = e;
        reset_i = 1'b0; tag_done_i = 1'b0; channel_en_i = 4'b1111;
        tick_to(r, TO - 1); cmp("to_early", 32'(timeout_o), 32'h0);
        tick_to(r, TO);     cmp("to_rise", 32'(timeout_o), 32'h1);
        tag_done_i = 1'b1;
        repeat (10) tick();
        cmp("to_sticky", 32'(timeout_o), 32'h1);
        cmp("to_reset_o", 32'(reset_o), 32'hF);
        do_reset();

        // Randomized traffic
        reset_i  = 1'b0;
        rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (reset_i) begin
                if (rst_hold == 0) reset_i = 1'b0;
                else rst_hold--;
            end else if ((exp_to && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0) begin
                reset_i  = 1'b1;
                rst_hold = $urandom_range(3, 5);
            end
            if ($urandom_range(0, 59) == 0) tag_done_i = ~tag_done_i;
            channel_en_i = N'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
